// File: rtl/timer_dev.sv
// Programmable countdown timer on the CPU data bus: CTRL/PRESET/COUNT registers, 4-state FSM, level irq.
// Optional TIMER_PRESCALE_EN: addr 3 becomes an 8-bit PRESCALE register that slows the count.
module timer_dev #(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t           state_q;
    logic [3:0]       ctrl_q;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] count_q;
    logic             intflag_q;
    logic             intflag_d;
`ifdef TIMER_PRESCALE_EN
    logic [7:0]       psc_q;
    logic [7:0]       div_q;
`endif

    logic wr_ctrl, wr_pre, wr_psc;
    logic en, auto_rl, tick, flag_set;

    assign wr_ctrl = sel & we & (addr == 2'd0);
    assign wr_pre  = sel & we & (addr == 2'd1);
    assign wr_psc  = sel & we & (addr == 2'd3);
    assign en      = ctrl_q[0];
    assign auto_rl = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
    assign tick = (div_q == psc_q);
`else
    assign tick = 1'b1;
`endif

    // Terminal count sets the flag; that wins over a same-edge register write clearing it.
    assign flag_set = (state_q == S_CNT) && en && tick && (count_q <= CNT_W'(1));

    always_comb begin
        intflag_d = intflag_q;
        if (wr_ctrl || wr_pre || (state_q == S_INT && auto_rl))
            intflag_d = 1'b0;
        if (flag_set)
            intflag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            preset_q  <= PRESET_RST;
            count_q   <= '0;
            intflag_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            psc_q     <= '0;
            div_q     <= '0;
`endif
        end else begin
            intflag_q <= intflag_d;
            case (state_q)
                S_IDLE: if (en) state_q <= S_LOAD;
                S_LOAD: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                    end else begin
                        count_q <= preset_q;
                        state_q <= S_CNT;
`ifdef TIMER_PRESCALE_EN
                        div_q   <= '0;
`endif
                    end
                end
                S_CNT: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                    end else begin
`ifdef TIMER_PRESCALE_EN
                        div_q <= tick ? 8'd0 : div_q + 8'd1;
`endif
                        if (tick) begin
                            if (count_q <= CNT_W'(1)) begin
                                count_q <= '0;
                                state_q <= S_INT;
                            end else begin
                                count_q <= count_q - CNT_W'(1);
                            end
                        end
                    end
                end
                S_INT: begin
                    if (!auto_rl) begin
                        ctrl_q[0] <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        state_q <= en ? S_LOAD : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Placed after the FSM so a CPU CTRL write overrides the one-shot EN clear.
            if (wr_ctrl) ctrl_q   <= wdata[3:0];
            if (wr_pre)  preset_q <= wdata[CNT_W-1:0];
`ifdef TIMER_PRESCALE_EN
            if (wr_psc)  psc_q    <= wdata[7:0];
`endif
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata = {28'd0, ctrl_q};
            2'd1: rdata = 32'(preset_q);
            2'd2: rdata = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
            2'd3: rdata = {24'd0, psc_q};
`else
            2'd3: rdata = {31'd0, wr_psc & 1'b0};
`endif
            default: rdata = '0;
        endcase
    end

    assign irq = intflag_q & ctrl_q[3];
endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: randomized register programs checked against closed-form timing rules.
module tb_timer_dev;
    logic        clk = 1'b0;
    logic        reset, sel, we;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        irq;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timer_dev #(.CNT_W(32), .PRESET_RST(32'h0)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    // Leave the timer stopped, flag clear, CTRL=0.
    task automatic idle();
        wr(2'd0, 32'h0);
        repeat (3) @(posedge clk);
        wr(2'd0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #2;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            n_checks++;
            if (v !== 32'h0) begin n_fail++; $display("FAIL reset_rdata addr=%0d got=%h exp=0", a, v); end
        end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_oneshot(input int n);
        logic [31:0] c, ct, ec;
        int d;
        logic ei;
        d = (n < 1) ? 1 : n;
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        for (int k = 0; k <= d + 6; k++) begin
            @(negedge clk);
            rd(2'd2, c);
            rd(2'd0, ct);
            ei = (k >= 2 + d);
            n_checks++;
            if (irq !== ei) begin n_fail++; $display("FAIL oneshot_irq n=%0d k=%0d got=%b exp=%b", n, k, irq, ei); end
            n_checks++;
            if (ct !== ((k >= 3 + d) ? 32'h8 : 32'h9)) begin
                n_fail++; $display("FAIL oneshot_ctrl n=%0d k=%0d got=%h", n, k, ct);
            end
            if (k >= 2) begin
                ec = (k - 2 < n) ? 32'(n - (k - 2)) : 32'h0;
                n_checks++;
                if (c !== ec) begin n_fail++; $display("FAIL oneshot_count n=%0d k=%0d got=%0d exp=%0d", n, k, c, ec); end
            end
        end
        wr(2'd0, 32'h8);
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear n=%0d got=%b exp=0", n, irq); end
        idle();
    endtask

    task automatic test_autoreload(input int n);
        logic [31:0] c, ec;
        int d, m, pulses, exp_pulses;
        logic ei;
        d = (n < 1) ? 1 : n;
        pulses = 0; exp_pulses = 0;
        wr(2'd1, n);
        wr(2'd0, 32'hB);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            rd(2'd2, c);
            m  = (k >= 2) ? (k - 2) % (d + 2) : -1;
            ei = (m == d);
            ec = (m >= 0 && m < n) ? 32'(n - m) : 32'h0;
            if (k >= 1 && k <= 20) begin
                if (irq === 1'b1) pulses++;
                if (ei) exp_pulses++;
            end
            n_checks++;
            if (irq !== ei) begin n_fail++; $display("FAIL auto_irq n=%0d k=%0d got=%b exp=%b", n, k, irq, ei); end
            if (k >= 2) begin
                n_checks++;
                if (c !== ec) begin n_fail++; $display("FAIL auto_count n=%0d k=%0d got=%0d exp=%0d", n, k, c, ec); end
            end
        end
        n_checks++;
        if (pulses !== exp_pulses) begin n_fail++; $display("FAIL auto_pulses n=%0d got=%0d exp=%0d", n, pulses, exp_pulses); end
        if (n == 3) begin
            n_checks++;
            if (pulses !== 4) begin n_fail++; $display("FAIL auto_pulses_20 got=%0d exp=4", pulses); end
        end
        idle();
    endtask

    task automatic test_mask();
        logic [31:0] c, ct;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq k=%0d got=%b exp=0", k, irq); end
        end
        rd(2'd2, c);
        rd(2'd0, ct);
        n_checks++;
        if (c !== 32'h0) begin n_fail++; $display("FAIL mask_count got=%0d exp=0", c); end
        n_checks++;
        if (ct !== 32'h0) begin n_fail++; $display("FAIL mask_ctrl got=%h exp=0", ct); end
        idle();
    endtask

    task automatic test_pause();
        logic [31:0] c;
        int n, w;
        n = $urandom_range(12, 30);
        w = n - 5;
        wr(2'd1, n);
        wr(2'd0, 32'h1);
        repeat (w - 1) @(posedge clk);
        wr(2'd0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd(2'd2, c);
            n_checks++;
            if (c !== 32'd7) begin n_fail++; $display("FAIL pause_hold n=%0d k=%0d got=%0d exp=7", n, k, c); end
        end
        idle();
    endtask

    task automatic test_regmap();
        logic [31:0] c0, c, v, p;
        @(negedge clk);
        rd(2'd2, c0);
        wr(2'd2, 32'h1234);
        rd(2'd2, c);
        n_checks++;
        if (c !== c0) begin n_fail++; $display("FAIL regmap_count_ro got=%h exp=%h", c, c0); end
        for (int i = 0; i < 3; i++) begin
            p = $urandom;
            wr(2'd1, p);
            rd(2'd1, v);
            n_checks++;
            if (v !== p) begin n_fail++; $display("FAIL regmap_preset got=%h exp=%h", v, p); end
        end
`ifndef TIMER_PRESCALE_EN
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL regmap_addr3 got=%h exp=0", v); end
`endif
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, v);
        n_checks++;
        if (v !== 32'hF) begin n_fail++; $display("FAIL regmap_ctrl_mask got=%h exp=f", v); end
        idle();
    endtask

    task automatic test_simul();
        logic [31:0] ct;
        int n, d;
        n = $urandom_range(2, 6);
        d = n;
        // CPU CTRL write on the one-shot INT exit edge keeps EN set.
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        repeat (d + 2) @(posedge clk);
        wr(2'd0, 32'h9);
        rd(2'd0, ct);
        n_checks++;
        if (ct !== 32'h9) begin n_fail++; $display("FAIL simul_ctrl_wins got=%h exp=9", ct); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL simul_ctrl_irq got=%b exp=0", irq); end
        idle();
        // PRESET write on the flag-set edge: the flag still sets.
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        repeat (d + 1) @(posedge clk);
        wr(2'd1, n);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL simul_set_wins got=%b exp=1", irq); end
        idle();
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] c, v, ec;
        int n, p, dec;
        logic ei;
        p = $urandom_range(1, 3);
        n = $urandom_range(2, 4);
        wr(2'd3, 32'hFFFF_FF00 | p);
        rd(2'd3, v);
        n_checks++;
        if (v !== 32'(p)) begin n_fail++; $display("FAIL psc_readback got=%h exp=%h", v, p); end
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        for (int k = 2; k <= 2 + n * (p + 1) + 2; k++) begin
            if (k == 2) repeat (2) @(negedge clk); else @(negedge clk);
            rd(2'd2, c);
            dec = (k - 2) / (p + 1);
            ec  = (dec < n) ? 32'(n - dec) : 32'h0;
            ei  = (dec >= n);
            n_checks++;
            if (c !== ec) begin n_fail++; $display("FAIL psc_count k=%0d got=%0d exp=%0d", k, c, ec); end
            n_checks++;
            if (irq !== ei) begin n_fail++; $display("FAIL psc_irq k=%0d got=%b exp=%b", k, irq, ei); end
        end
        idle();
        wr(2'd3, 32'h0);
    endtask
`endif

    task automatic test_reset_midcount();
        logic [31:0] v;
        wr(2'd1, 32'h40);
        wr(2'd0, 32'h9);
        repeat (32'h22) @(posedge clk);
        @(negedge clk);
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'h20) begin n_fail++; $display("FAIL midreset_precount got=%h exp=20", v); end
        reset = 1'b0;
        #1;
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_count got=%h exp=0", v); end
        rd(2'd0, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_ctrl got=%h exp=0", v); end
        rd(2'd1, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_preset got=%h exp=0", v); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq got=%b exp=0", irq); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;
        test_reset();
        test_oneshot(5);
        for (int i = 0; i < 3; i++) test_oneshot($urandom_range(0, 10));
        test_autoreload(3);
        for (int i = 0; i < 2; i++) test_autoreload($urandom_range(0, 6));
        test_mask();
        test_pause();
        test_regmap();
        test_simul();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
